// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise logic unit.
// Holds the operation width and the operation encodings used by the top
// module and the combinational operation block.
package bitwise_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND      = 3'd0,
    OP_OR       = 3'd1,
    OP_XOR      = 3'd2,
    OP_XNOR     = 3'd3,
    OP_NAND     = 3'd4,
    OP_NOR      = 3'd5,
    OP_ACC_XOR  = 3'd6,
    OP_ACC_LOAD = 3'd7
  } op_e;

endpackage

// File: rtl/bitwise_op_comb.sv
// Combinational operation block of the bitwise logic unit.
// Ports:
//   op       operation select
//   a, b     operands (b unused by the accumulator ops)
//   acc_base accumulator value after any same-cycle clear
//   res      operation result
module bitwise_op_comb
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_base,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_AND:      res = a & b;
      OP_OR:       res = a | b;
      OP_XOR:      res = a ^ b;
      OP_XNOR:     res = ~(a ^ b);
      OP_NAND:     res = ~(a & b);
      OP_NOR:      res = ~(a | b);
      OP_ACC_XOR:  res = acc_base ^ a;
      OP_ACC_LOAD: res = a;
      default:     res = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake, running XOR
// accumulator and wrapping beat counter.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input beat handshake (in_ready is combinational)
//   op, a, b             operation select and operands
//   clr_acc              synchronous accumulator clear pulse
//   out_valid, out_ready output result handshake
//   f, parity            registered result and its XOR reduction
//   acc                  accumulator value
//   beat_cnt             accepted beats modulo 2^CNT_W
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             accept;
  logic             acc_op;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_op   = (op == OP_ACC_XOR) || (op == OP_ACC_LOAD);

  // The clear is applied before an accumulate in the same cycle.
  assign acc_base = clr_acc ? '0 : acc;

  bitwise_op_comb #(
    .WIDTH(WIDTH)
  ) u_op (
    .op      (op),
    .a       (a),
    .b       (b),
    .acc_base(acc_base),
    .res     (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      f         <= '0;
      parity    <= 1'b0;
      acc       <= '0;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        f         <= res;
        parity    <= ^res;
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && acc_op) begin
        acc <= res;
      end else if (clr_acc) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=16, CNT_W=4).
module tb_bitwise_logic_unit;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             parity;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bitwise_logic_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .clr_acc  (clr_acc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .parity   (parity),
    .acc      (acc),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] av,
                       input logic [15:0] bv);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
  endtask

  initial begin : stim
    logic [15:0] exp_ops [6];
    logic [15:0] wrap_a;
    exp_ops[0] = 16'hA0A0;
    exp_ops[1] = 16'hFAFA;
    exp_ops[2] = 16'h5A5A;
    exp_ops[3] = 16'hA5A5;
    exp_ops[4] = 16'h5F5F;
    exp_ops[5] = 16'h0505;

    // Reset state, observed while rst is still asserted.
    rst = 1'b1; clr_acc = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f",         32'(f),         32'd0);
    check("rst_parity",    32'(parity),    32'd0);
    check("rst_acc",       32'(acc),       32'd0);
    check("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    step();

    // First XOR beat.
    drive(1'b1, 3'd2, 16'hAAAA, 16'hCCCC);
    step();
    check("xor_f",         32'(f),         32'h6666);
    check("xor_parity",    32'(parity),    32'd0);
    check("xor_out_valid", 32'(out_valid), 32'd1);
    check("xor_beat_cnt",  32'(beat_cnt),  32'd1);

    // Ops 0-5 back to back.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 16'hF0F0, 16'hAAAA);
      step();
      check($sformatf("op%0d_f", i), 32'(f), 32'(exp_ops[i]));
    end
    check("ops_beat_cnt", 32'(beat_cnt), 32'd7);
    check("ops_acc",      32'(acc),      32'd0);

    // Idle with out_ready=1: result consumed, f holds.
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_f_hold",    32'(f),         32'h0505);

    // Backpressure.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'hFFFF, 16'h0F0F);
    step();
    check("bp_and_f",      32'(f),        32'h0F0F);
    check("bp_in_ready",   32'(in_ready), 32'd0);
    check("bp_beat_cnt",   32'(beat_cnt), 32'd8);
    drive(1'b1, 3'd1, 16'h1234, 16'h4321);
    step();
    check("bp_hold_f",        32'(f),         32'h0F0F);
    check("bp_hold_out_valid",32'(out_valid), 32'd1);
    check("bp_hold_beat_cnt", 32'(beat_cnt),  32'd8);
    check("bp_hold_in_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_or_f",        32'(f),        32'h5335);
    check("bp_or_beat_cnt", 32'(beat_cnt), 32'd9);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    step();
    check("bp_drain_out_valid", 32'(out_valid), 32'd0);

    // Accumulate.
    clr_acc = 1'b1;
    step();
    clr_acc = 1'b0;
    check("acc_clr", 32'(acc), 32'd0);
    drive(1'b1, 3'd6, 16'h1234, 16'hFFFF);
    step();
    check("acc1_acc", 32'(acc), 32'h1234);
    check("acc1_f",   32'(f),   32'h1234);
    drive(1'b1, 3'd6, 16'h0F0F, 16'hFFFF);
    step();
    check("acc2_acc", 32'(acc), 32'h1D3B);
    check("acc2_f",   32'(f),   32'h1D3B);
    drive(1'b1, 3'd6, 16'h1234, 16'hFFFF);
    step();
    check("acc3_acc",    32'(acc),    32'h0F0F);
    check("acc3_f",      32'(f),      32'h0F0F);
    check("acc3_parity", 32'(parity), 32'd0);
    drive(1'b1, 3'd6, 16'h1234, 16'h0000);
    step();
    check("acc4_acc", 32'(acc), 32'h1D3B);

    // Clear together with an accepted op 6.
    clr_acc = 1'b1;
    drive(1'b1, 3'd6, 16'h00FF, 16'h0000);
    step();
    check("clr_op6_acc", 32'(acc), 32'h00FF);
    check("clr_op6_f",   32'(f),   32'h00FF);
    // Clear alone.
    drive(1'b0, 3'd6, 16'h1111, 16'h0000);
    step();
    clr_acc = 1'b0;
    check("clr_alone_acc", 32'(acc), 32'd0);
    check("clr_alone_f",   32'(f),   32'h00FF);
    // Load.
    drive(1'b1, 3'd7, 16'hBEEF, 16'h1234);
    step();
    check("load_acc",      32'(acc),      32'hBEEF);
    check("load_f",        32'(f),        32'hBEEF);
    check("load_parity",   32'(parity),   32'd1);
    check("load_beat_cnt", 32'(beat_cnt), 32'd15);
    // Logic op leaves acc alone; counter wraps 15 -> 0.
    drive(1'b1, 3'd2, 16'hFFFF, 16'h0000);
    step();
    check("logic_acc_hold", 32'(acc),      32'hBEEF);
    check("wrap_first",     32'(beat_cnt), 32'd0);

    // Sixteen more beats return the counter to 0, the next gives 1.
    for (int i = 0; i < 16; i++) begin
      wrap_a = 16'(i * 16'h0101);
      drive(1'b1, 3'd2, wrap_a, 16'h00FF);
      step();
    end
    check("wrap_f",    32'(f),        32'(16'h0F0F ^ 16'h00FF));
    check("wrap_16",   32'(beat_cnt), 32'd0);
    drive(1'b1, 3'd2, 16'h0001, 16'h0000);
    step();
    check("wrap_17",   32'(beat_cnt), 32'd1);

    // Asynchronous reset with a pending, unconsumed result.
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h0003, 16'h0000);
    step();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_acc",       32'(acc),       32'hBEEF);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_f",         32'(f),         32'd0);
    check("arst_acc",       32'(acc),       32'd0);
    check("arst_beat_cnt",  32'(beat_cnt),  32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    step();
    check("arst_no_accept", 32'(beat_cnt),  32'd0);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    drive(1'b1, 3'd2, 16'hAAAA, 16'hCCCC);
    step();
    check("post_rst_f",         32'(f),         32'h6666);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_beat_cnt",  32'(beat_cnt),  32'd1);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
